// File: rtl/dma_read_loader.sv
// dma_read_loader
//   DMA read sequencer. On `start` it latches NUM_SEG segment descriptors
//   (DMA word index, length in words, SRAM base word address). For each
//   non-empty segment, in order, it issues one request on the DMA read control
//   channel. It then accepts ceil(length/LANES) beats on the data channel,
//   splits each beat into LANES words and writes them, one cycle later, to the
//   SRAM write ports. Words past the end of the segment are masked off.
//
// Optional feature: define DMA_READ_LOADER_PERF_EN to add the perf_beats /
//   perf_stall counters and ports. Without it they are absent.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      one-cycle request, accepted only when idle
//   cfg_index/length/base      packed per-segment descriptors (segment s at slot s)
//   busy, done                 busy from the cycle after start through done; done pulse
//   dma_read_ctrl_*            request handshake (index, length, size=3'b010)
//   dma_read_chnl_*            beat handshake and data
//   wr_en/wr_addr/wr_data      registered per-lane SRAM write port
//   wr_seg                     segment number of the current write (bank decode)
//   perf_beats, perf_stall     (DMA_READ_LOADER_PERF_EN only) saturating counters
module dma_read_loader #(
    parameter int BEAT_WIDTH = 64,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_SEG    = 2,
    parameter int ADDR_WIDTH = 16,
    localparam int LANES     = BEAT_WIDTH / WORD_WIDTH,
    localparam int SEG_W     = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_SEG*32-1:0]         cfg_index,
    input  logic [NUM_SEG*32-1:0]         cfg_length,
    input  logic [NUM_SEG*ADDR_WIDTH-1:0] cfg_base,
    output logic                          busy,
    output logic                          done,
    output logic                          dma_read_ctrl_valid,
    input  logic                          dma_read_ctrl_ready,
    output logic [31:0]                   dma_read_ctrl_data_index,
    output logic [31:0]                   dma_read_ctrl_data_length,
    output logic [2:0]                    dma_read_ctrl_data_size,
    input  logic                          dma_read_chnl_valid,
    input  logic [BEAT_WIDTH-1:0]         dma_read_chnl_data,
    output logic                          dma_read_chnl_ready,
    output logic [LANES-1:0]              wr_en,
    output logic [LANES*ADDR_WIDTH-1:0]   wr_addr,
    output logic [BEAT_WIDTH-1:0]         wr_data,
    output logic [SEG_W-1:0]              wr_seg
`ifdef DMA_READ_LOADER_PERF_EN
    ,
    output logic [31:0]                   perf_beats,
    output logic [31:0]                   perf_stall
`endif
);

    // Segment counter must be able to hold NUM_SEG itself ("past the last segment").
    localparam int SEG_CW = $clog2(NUM_SEG + 1);
    localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(NUM_SEG - 1);
    localparam logic [SEG_CW-1:0] SEG_END  = SEG_CW'(NUM_SEG);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_CTRL, S_CHNL, S_DONE} state_e;

    state_e                        state_q, state_d;
    logic [SEG_CW-1:0]             seg_q, seg_d;
    // Word offset of the next beat inside the segment (beat count * LANES).
    logic [31:0]                   word_q, word_d;
    logic [NUM_SEG*32-1:0]         idx_q, idx_d, len_q, len_d;
    logic [NUM_SEG*ADDR_WIDTH-1:0] base_q, base_d;
    logic [LANES-1:0]              wr_en_q, wr_en_d;
    logic [LANES*ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [BEAT_WIDTH-1:0]         wr_data_q, wr_data_d;
    logic [SEG_W-1:0]              wr_seg_q, wr_seg_d;

    logic [SEG_W-1:0]      seg_sel;
    logic [31:0]           cur_idx, cur_len;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic                  ctrl_hs, chnl_hs, last_beat;

    // seg_sel is only used while seg_q < NUM_SEG; SEL tests for the end first.
    assign seg_sel   = seg_q[SEG_W-1:0];
    assign cur_idx   = idx_q[32*seg_sel +: 32];
    assign cur_len   = len_q[32*seg_sel +: 32];
    assign cur_base  = base_q[ADDR_WIDTH*seg_sel +: ADDR_WIDTH];
    assign ctrl_hs   = (state_q == S_CTRL) && dma_read_ctrl_ready;
    assign chnl_hs   = (state_q == S_CHNL) && dma_read_chnl_valid;
    // Widened by one bit so offset + LANES cannot wrap for lengths near 2^32.
    assign last_beat = ({1'b0, word_q} + 33'(LANES)) >= {1'b0, cur_len};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        seg_d     = seg_q;
        word_d    = word_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_seg_d  = wr_seg_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEL;
                    seg_d   = '0;
                    idx_d   = cfg_index;
                    len_d   = cfg_length;
                    base_d  = cfg_base;
                end
            end
            S_SEL: begin
                if (seg_q == SEG_END) begin
                    state_d = S_DONE;
                end else if (cur_len == '0) begin
                    // Skipping the final segment goes straight to DONE to save a cycle.
                    seg_d = seg_q + SEG_CW'(1);
                    if (seg_q == SEG_LAST) state_d = S_DONE;
                end else begin
                    state_d = S_CTRL;
                end
            end
            S_CTRL: begin
                if (ctrl_hs) begin
                    state_d = S_CHNL;
                    word_d  = '0;
                end
            end
            S_CHNL: begin
                if (chnl_hs) begin
                    wr_seg_d  = seg_sel;
                    wr_data_d = dma_read_chnl_data;
                    for (int l = 0; l < LANES; l++) begin
                        wr_en_d[l] = ({1'b0, word_q} + 33'(l)) < {1'b0, cur_len};
                        wr_addr_d[l*ADDR_WIDTH +: ADDR_WIDTH] =
                            cur_base + ADDR_WIDTH'(word_q) + ADDR_WIDTH'(l);
                    end
                    word_d = word_q + 32'(LANES);
                    if (last_beat) begin
                        state_d = S_SEL;
                        seg_d   = seg_q + SEG_CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            seg_q     <= '0;
            word_q    <= '0;
            // NOTE: descriptor storage is a small register bank, so it is reset like any other state.
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_seg_q  <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_seg_q  <= wr_seg_d;
        end
    end

    // Handshake outputs decode the state directly so valid cannot drop before ready.
    assign busy                      = (state_q != S_IDLE);
    assign done                      = (state_q == S_DONE);
    assign dma_read_ctrl_valid       = (state_q == S_CTRL);
    assign dma_read_ctrl_data_index  = dma_read_ctrl_valid ? cur_idx : '0;
    assign dma_read_ctrl_data_length = dma_read_ctrl_valid ? cur_len : '0;
    assign dma_read_ctrl_data_size   = dma_read_ctrl_valid ? 3'b010 : 3'b000;
    assign dma_read_chnl_ready       = (state_q == S_CHNL);
    assign wr_en                     = wr_en_q;
    assign wr_addr                   = wr_addr_q;
    assign wr_data                   = wr_data_q;
    assign wr_seg                    = wr_seg_q;

`ifdef DMA_READ_LOADER_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d, perf_stall_q, perf_stall_d;
    logic        stall_cycle;

    assign stall_cycle = ((state_q == S_CTRL) && !ctrl_hs) || ((state_q == S_CHNL) && !chnl_hs);

    always_comb begin
        perf_beats_d = perf_beats_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == S_IDLE) && start) begin
            perf_beats_d = '0;
            perf_stall_d = '0;
        end else begin
            if (chnl_hs && (perf_beats_q != '1))     perf_beats_d = perf_beats_q + 32'd1;
            if (stall_cycle && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_beats = perf_beats_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
